dcache_req_sched: RTL and testbench
===================================

Name: dcache_req_sched

Overview:
- Schedules access to the single write-back dcache controller pipeline.
- Requesters are NR_PORTS CPU load/store ports plus one coherence snoop channel (AC).
- Exactly one transaction is in flight at a time: from grant until the controller signals completion.
- Snoops have priority, bounded by an anti-starvation limit; CPU ports are served round-robin.

Parameters:
NR_PORTS, 3, number of CPU requester ports
ADDR_W, 64, request address width
STARVE_LIMIT, 4, max consecutive snoop grants while any CPU request is pending

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
cpu_req_i  in  NR_PORTS  per-port request; held until granted
cpu_we_i  in  NR_PORTS  per-port write flag
cpu_addr_i  in  NR_PORTS*ADDR_W  per-port address, port p at [p*ADDR_W +: ADDR_W]
cpu_gnt_o  out  NR_PORTS  one-cycle grant pulse to the winning port
snoop_valid_i  in  1  AC valid
snoop_addr_i  in  ADDR_W  AC address
snoop_type_i  in  4  AC snoop opcode
snoop_ready_o  out  1  AC ready; one-cycle pulse
ctrl_req_o  out  1  request to cache controller
ctrl_kind_o  out  2  RD=0, WR=1, SNOOP=2
ctrl_port_o  out  $clog2(NR_PORTS)  originating CPU port (0 for snoop)
ctrl_addr_o  out  ADDR_W  transaction address
ctrl_snoop_type_o  out  4  registered snoop opcode
ctrl_gnt_i  in  1  controller accepts ctrl_req_o
ctrl_done_i  in  1  controller finished the transaction (one-cycle pulse)
busy_o  out  1  a transaction is granted or in flight

Behaviour:
- Reset: all outputs 0; state IDLE; rr_ptr=0; starve_cnt=0. Applies identically mid-transaction; a later ctrl_done_i is ignored while in IDLE.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT_DONE.
- IDLE: if any request is present in cycle n, select a winner.
  - Latch addr, kind, port and snoop_type.
  - Pulse cpu_gnt_o[w] or snoop_ready_o in cycle n+1.
  - Enter ISSUE with ctrl_req_o=1 in cycle n+1.
  - With no request, stay in IDLE.
- ISSUE: hold ctrl_req_o and all ctrl_* fields stable until ctrl_gnt_i=1, then go to WAIT_DONE with ctrl_req_o=0 next cycle.
- ISSUE, simultaneous ctrl_gnt_i and ctrl_done_i: go straight to IDLE.
- WAIT_DONE: on ctrl_done_i go to IDLE. A new selection is possible in the IDLE cycle, so back-to-back issue gap is ≥1 cycle.
- busy_o = (state != IDLE).
- Selection, snoop priority:
  - Snoop wins if snoop_valid_i and (no cpu_req_i set, or starve_cnt < STARVE_LIMIT).
  - Otherwise a CPU port wins: the first set bit of cpu_req_i at or after rr_ptr, wrapping modulo NR_PORTS.
  - After a CPU grant to port w: rr_ptr = (w+1) mod NR_PORTS (wrap from NR_PORTS-1 to 0).
- starve_cnt:
  - Increments on a snoop grant while any cpu_req_i is set; saturates at STARVE_LIMIT.
  - Clears on any CPU grant, and on a snoop grant with no CPU request pending.
- Requests arriving while busy are not acknowledged. Requesters keep cpu_req_i / snoop_valid_i asserted; inputs are sampled only in IDLE.
- ctrl_kind_o: SNOOP for a snoop winner, else WR if cpu_we_i[w], else RD.

Optional Feature:
- Macro DCACHE_REQ_SCHED_PERF_EN.
- Defined:
  - Adds outputs perf_snoop_cnt_o[31:0], perf_cpu_cnt_o[31:0] and perf_stall_cyc_o[31:0].
  - perf_stall_cyc_o counts cycles with any request pending while busy_o=1.
  - All counters increment on grants / stall cycles, reset to 0 and wrap at 2^32.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package dcache_sched_pkg:
  - req_kind_e enum (RD/WR/SNOOP).
  - sched_state_e enum.
  - sched_req_t struct {kind, port, addr, snoop_type}.
- One sub-module, dcache_rr_picker: combinational round-robin first-set-from-pointer, with parameter NR_PORTS and ports req, ptr, valid, idx.

Test Plan:
- Single request: port1 read at 0x8000_0040, ctrl_gnt_i 2 cycles later, ctrl_done_i 5 cycles later -> cpu_gnt_o=0b010 one cycle after req; ctrl_kind_o=RD, ctrl_addr_o=0x8000_0040 stable until gnt; busy_o falls the cycle after done.
- Round-robin wrap: ports 0,1,2 request continuously, immediate gnt/done -> grant order 0,1,2,0,1; rr_ptr wraps from 2 to 0.
- Snoop priority and starvation: snoop_valid_i held high plus port2 req, STARVE_LIMIT=4 -> 4 snoop grants, then port2 granted, then snoops resume.
- Simultaneous snoop and CPU arrival in IDLE with starve_cnt=0 -> snoop_ready_o pulses; ctrl_kind_o=SNOOP; cpu_gnt_o stays 0 until that transaction completes.
- Gnt and done in the same cycle in ISSUE -> returns to IDLE, next request issued with 1-cycle gap.
- Reset asserted in WAIT_DONE -> next cycle all outputs 0, rr_ptr=0; a subsequent stray ctrl_done_i has no effect.

Source files
------------

// File: rtl/dcache_sched_pkg.sv
// Shared types for the dcache request scheduler: transaction kinds, FSM states and the
// latched request record.
package dcache_sched_pkg;

    // Upper bounds for the latched request record; the top slices down to its parameters.
    localparam int unsigned SchedMaxPortW = 8;
    localparam int unsigned SchedMaxAddrW = 64;

    typedef enum logic [1:0] {
        KindRd    = 2'd0,
        KindWr    = 2'd1,
        KindSnoop = 2'd2
    } req_kind_e;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StIssue    = 2'd1,
        StWaitDone = 2'd2
    } sched_state_e;

    typedef struct packed {
        req_kind_e                kind;
        logic [SchedMaxPortW-1:0] port;
        logic [SchedMaxAddrW-1:0] addr;
        logic [3:0]               snoop_type;
    } sched_req_t;

endpackage

// File: rtl/dcache_rr_picker.sv
// Combinational round-robin picker: returns the first set request bit at or after ptr,
// wrapping modulo NR_PORTS.
module dcache_rr_picker #(
    parameter int unsigned NR_PORTS = 3,
    localparam int unsigned PW = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1
) (
    input  logic [NR_PORTS-1:0] req,
    input  logic [PW-1:0]       ptr,
    output logic                valid,
    output logic [PW-1:0]       idx
);

    int unsigned cand;
    logic [PW-1:0] cand_idx;

    // Walk offsets from farthest to nearest so the nearest set bit is assigned last.
    always_comb begin
        valid    = 1'b0;
        idx      = '0;
        cand     = 0;
        cand_idx = '0;
        for (int i = int'(NR_PORTS) - 1; i >= 0; i--) begin
            cand     = (32'(ptr) + 32'(i)) % NR_PORTS;
            cand_idx = PW'(cand);
            if (req[cand_idx]) begin
                valid = 1'b1;
                idx   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/dcache_req_sched.sv
// Single-outstanding scheduler in front of the dcache controller: snoops first (bounded by
// STARVE_LIMIT), CPU ports round-robin. Define DCACHE_REQ_SCHED_PERF_EN for perf counters.
module dcache_req_sched
    import dcache_sched_pkg::*;
#(
    parameter int unsigned NR_PORTS     = 3,
    parameter int unsigned ADDR_W       = 64,
    parameter int unsigned STARVE_LIMIT = 4,
    localparam int unsigned PW = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NR_PORTS-1:0]        cpu_req_i,
    input  logic [NR_PORTS-1:0]        cpu_we_i,
    input  logic [NR_PORTS*ADDR_W-1:0] cpu_addr_i,
    output logic [NR_PORTS-1:0]        cpu_gnt_o,
    input  logic                       snoop_valid_i,
    input  logic [ADDR_W-1:0]          snoop_addr_i,
    input  logic [3:0]                 snoop_type_i,
    output logic                       snoop_ready_o,
    output logic                       ctrl_req_o,
    output logic [1:0]                 ctrl_kind_o,
    output logic [PW-1:0]              ctrl_port_o,
    output logic [ADDR_W-1:0]          ctrl_addr_o,
    output logic [3:0]                 ctrl_snoop_type_o,
    input  logic                       ctrl_gnt_i,
    input  logic                       ctrl_done_i,
    output logic                       busy_o
`ifdef DCACHE_REQ_SCHED_PERF_EN
    ,
    output logic [31:0]                perf_snoop_cnt_o,
    output logic [31:0]                perf_cpu_cnt_o,
    output logic [31:0]                perf_stall_cyc_o
`endif
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    sched_state_e        state_q, state_d;
    sched_req_t          cur_q, cur_d;
    logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [SW-1:0]       starve_q, starve_d;
    logic [NR_PORTS-1:0] cpu_gnt_q, cpu_gnt_d;
    logic                snoop_ready_q, snoop_ready_d;
    logic                ctrl_req_q, ctrl_req_d;
    logic                busy_q, busy_d;
    logic                cpu_valid, snoop_win, snoop_grant, cpu_grant;
    logic [PW-1:0]       cpu_idx;

    dcache_rr_picker #(
        .NR_PORTS (NR_PORTS)
    ) u_picker (
        .req   (cpu_req_i),
        .ptr   (rr_ptr_q),
        .valid (cpu_valid),
        .idx   (cpu_idx)
    );

    assign snoop_win = snoop_valid_i && (!cpu_valid || (starve_q < SW'(STARVE_LIMIT)));

    always_comb begin
        state_d       = state_q;
        cur_d         = cur_q;
        rr_ptr_d      = rr_ptr_q;
        starve_d      = starve_q;
        cpu_gnt_d     = '0;
        snoop_ready_d = 1'b0;
        ctrl_req_d    = ctrl_req_q;
        snoop_grant   = 1'b0;
        cpu_grant     = 1'b0;
        case (state_q)
            StIdle: begin
                if (snoop_win) begin
                    snoop_grant      = 1'b1;
                    cur_d.kind       = KindSnoop;
                    cur_d.port       = '0;
                    cur_d.addr       = SchedMaxAddrW'(snoop_addr_i);
                    cur_d.snoop_type = snoop_type_i;
                    snoop_ready_d    = 1'b1;
                    ctrl_req_d       = 1'b1;
                    state_d          = StIssue;
                    // Only snoops that bypass a waiting CPU count towards starvation.
                    if (!cpu_valid) begin
                        starve_d = '0;
                    end else if (starve_q != SW'(STARVE_LIMIT)) begin
                        starve_d = starve_q + 1'b1;
                    end
                end else if (cpu_valid) begin
                    cpu_grant          = 1'b1;
                    cur_d.kind         = cpu_we_i[cpu_idx] ? KindWr : KindRd;
                    cur_d.port         = SchedMaxPortW'(cpu_idx);
                    cur_d.addr         = SchedMaxAddrW'(cpu_addr_i[int'(cpu_idx)*ADDR_W +: ADDR_W]);
                    cur_d.snoop_type   = '0;
                    cpu_gnt_d[cpu_idx] = 1'b1;
                    ctrl_req_d         = 1'b1;
                    state_d            = StIssue;
                    starve_d           = '0;
                    rr_ptr_d = (cpu_idx == PW'(NR_PORTS - 1)) ? '0 : cpu_idx + 1'b1;
                end
            end
            StIssue: begin
                if (ctrl_gnt_i) begin
                    ctrl_req_d = 1'b0;
                    state_d    = ctrl_done_i ? StIdle : StWaitDone;
                end
            end
            StWaitDone: begin
                if (ctrl_done_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            cur_q         <= '0;
            rr_ptr_q      <= '0;
            starve_q      <= '0;
            cpu_gnt_q     <= '0;
            snoop_ready_q <= 1'b0;
            ctrl_req_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_q         <= cur_d;
            rr_ptr_q      <= rr_ptr_d;
            starve_q      <= starve_d;
            cpu_gnt_q     <= cpu_gnt_d;
            snoop_ready_q <= snoop_ready_d;
            ctrl_req_q    <= ctrl_req_d;
            busy_q        <= busy_d;
        end
    end

    assign cpu_gnt_o         = cpu_gnt_q;
    assign snoop_ready_o     = snoop_ready_q;
    assign ctrl_req_o        = ctrl_req_q;
    assign ctrl_kind_o       = cur_q.kind;
    assign ctrl_port_o       = cur_q.port[PW-1:0];
    assign ctrl_addr_o       = cur_q.addr[ADDR_W-1:0];
    assign ctrl_snoop_type_o = cur_q.snoop_type;
    assign busy_o            = busy_q;

    // The record is sized for the widest configuration; surplus bits are intentionally dropped.
    logic unused_cur;
    assign unused_cur = ^{cur_q.port, cur_q.addr};

`ifdef DCACHE_REQ_SCHED_PERF_EN
    logic [31:0] perf_snoop_q, perf_cpu_q, perf_stall_q;
    logic        any_req;

    assign any_req = (|cpu_req_i) | snoop_valid_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_snoop_q <= '0;
            perf_cpu_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            if (snoop_grant)       perf_snoop_q <= perf_snoop_q + 32'd1;
            if (cpu_grant)         perf_cpu_q   <= perf_cpu_q + 32'd1;
            if (any_req && busy_q) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_snoop_cnt_o = perf_snoop_q;
    assign perf_cpu_cnt_o   = perf_cpu_q;
    assign perf_stall_cyc_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_dcache_req_sched.sv
// Directed bench for dcache_req_sched: expected transactions are queued when requests are
// raised and compared when the scheduler issues them to the controller.
module tb_dcache_req_sched;

    localparam int NP = 3;
    localparam int AW = 64;

    typedef struct packed {
        logic [1:0]  kind;
        logic [1:0]  port;
        logic [63:0] addr;
        logic [3:0]  stype;
        logic        drop;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_i;
    logic [NP-1:0]   cpu_req_i, cpu_we_i, cpu_gnt_o;
    logic [NP*AW-1:0] cpu_addr_i;
    logic            snoop_valid_i, snoop_ready_o;
    logic [AW-1:0]   snoop_addr_i, ctrl_addr_o;
    logic [3:0]      snoop_type_i, ctrl_snoop_type_o;
    logic            ctrl_req_o, ctrl_gnt_i, ctrl_done_i, busy_o;
    logic [1:0]      ctrl_kind_o, ctrl_port_o;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t e;
    int   n;

    dcache_req_sched #(
        .NR_PORTS     (NP),
        .ADDR_W       (AW),
        .STARVE_LIMIT (4)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .cpu_req_i         (cpu_req_i),
        .cpu_we_i          (cpu_we_i),
        .cpu_addr_i        (cpu_addr_i),
        .cpu_gnt_o         (cpu_gnt_o),
        .snoop_valid_i     (snoop_valid_i),
        .snoop_addr_i      (snoop_addr_i),
        .snoop_type_i      (snoop_type_i),
        .snoop_ready_o     (snoop_ready_o),
        .ctrl_req_o        (ctrl_req_o),
        .ctrl_kind_o       (ctrl_kind_o),
        .ctrl_port_o       (ctrl_port_o),
        .ctrl_addr_o       (ctrl_addr_o),
        .ctrl_snoop_type_o (ctrl_snoop_type_o),
        .ctrl_gnt_i        (ctrl_gnt_i),
        .ctrl_done_i       (ctrl_done_i),
        .busy_o            (busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_req"}, 64'(ctrl_req_o), 0);
        check({tag, "_gnt"}, 64'(cpu_gnt_o), 0);
        check({tag, "_srdy"}, 64'(snoop_ready_o), 0);
        check({tag, "_kind"}, 64'(ctrl_kind_o), 0);
        check({tag, "_port"}, 64'(ctrl_port_o), 0);
        check({tag, "_addr"}, ctrl_addr_o, 0);
        check({tag, "_stype"}, 64'(ctrl_snoop_type_o), 0);
        check({tag, "_busy"}, 64'(busy_o), 0);
    endtask

    task automatic reset_dut();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
    endtask

    task automatic set_addr(input int p, input logic [63:0] a);
        cpu_addr_i[p*AW +: AW] = a;
    endtask

    task automatic push_cpu(input logic [1:0] p, input bit we, input logic [63:0] a,
                            input bit drop);
        exp_t x;
        x.kind = we ? 2'd1 : 2'd0;
        x.port = p;
        x.addr = a;
        x.stype = 4'd0;
        x.drop = drop;
        sb.push_back(x);
    endtask

    task automatic push_snoop(input logic [63:0] a, input logic [3:0] t, input bit drop);
        exp_t x;
        x.kind = 2'd2;
        x.port = 2'd0;
        x.addr = a;
        x.stype = t;
        x.drop = drop;
        sb.push_back(x);
    endtask

    // Waits for the issue cycle, compares it with the scoreboard head, releases the requester.
    task automatic wait_issue(output int cyc, output exp_t x);
        logic [2:0] exp_gnt;
        cyc = 0;
        while (ctrl_req_o !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        check("issue_seen", 64'(ctrl_req_o), 1);
        check("sb_pending", 64'(sb.size() > 0), 1);
        x = (sb.size() > 0) ? sb.pop_front() : '0;
        exp_gnt = (x.kind == 2'd2) ? 3'b000 : (3'b001 << x.port);
        check("kind", 64'(ctrl_kind_o), 64'(x.kind));
        check("port", 64'(ctrl_port_o), 64'(x.port));
        check("addr", ctrl_addr_o, x.addr);
        check("cpu_gnt", 64'(cpu_gnt_o), 64'(exp_gnt));
        check("snoop_ready", 64'(snoop_ready_o), 64'(x.kind == 2'd2));
        check("busy_issue", 64'(busy_o), 1);
        if (x.kind == 2'd2) check("stype", 64'(ctrl_snoop_type_o), 64'(x.stype));
        if (x.drop) begin
            if (x.kind == 2'd2) snoop_valid_i = 1'b0;
            else cpu_req_i[x.port] = 1'b0;
        end
    endtask

    task automatic finish_txn(input exp_t x, input int gnt_dly, input int done_dly,
                              input bit same);
        repeat (gnt_dly) begin
            tick();
            check("hold_req", 64'(ctrl_req_o), 1);
            check("hold_addr", ctrl_addr_o, x.addr);
            check("hold_kind", 64'(ctrl_kind_o), 64'(x.kind));
            check("hold_no_gnt", 64'({cpu_gnt_o, snoop_ready_o}), 0);
        end
        ctrl_gnt_i = 1'b1;
        ctrl_done_i = same;
        tick();
        ctrl_gnt_i = 1'b0;
        ctrl_done_i = 1'b0;
        check("req_drop", 64'(ctrl_req_o), 0);
        if (same) begin
            check("same_idle", 64'(busy_o), 0);
        end else begin
            repeat (done_dly) begin
                check("wait_busy", 64'(busy_o), 1);
                check("wait_no_gnt", 64'({cpu_gnt_o, snoop_ready_o}), 0);
                tick();
            end
            ctrl_done_i = 1'b1;
            tick();
            ctrl_done_i = 1'b0;
            check("done_idle", 64'(busy_o), 0);
        end
    endtask

    initial begin
        rst_i = 1'b1;
        cpu_req_i = '0;
        cpu_we_i = '0;
        cpu_addr_i = '0;
        snoop_valid_i = 1'b0;
        snoop_addr_i = '0;
        snoop_type_i = '0;
        ctrl_gnt_i = 1'b0;
        ctrl_done_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
        check_zero("reset");

        // Single port-1 read.
        set_addr(1, 64'h8000_0040);
        cpu_req_i = 3'b010;
        push_cpu(2'd1, 1'b0, 64'h8000_0040, 1'b1);
        wait_issue(n, e);
        check("t1_latency", 64'(n), 1);
        finish_txn(e, 2, 5, 1'b0);

        // Round-robin wrap with all ports requesting continuously.
        reset_dut();
        for (int p = 0; p < NP; p++) set_addr(p, 64'h1000 + 64'(p) * 64'h40);
        cpu_req_i = 3'b111;
        push_cpu(2'd0, 1'b0, 64'h1000, 1'b0);
        push_cpu(2'd1, 1'b0, 64'h1040, 1'b0);
        push_cpu(2'd2, 1'b0, 64'h1080, 1'b0);
        push_cpu(2'd0, 1'b0, 64'h1000, 1'b0);
        push_cpu(2'd1, 1'b0, 64'h1040, 1'b0);
        repeat (5) begin
            wait_issue(n, e);
            finish_txn(e, 0, 0, 1'b0);
        end
        cpu_req_i = '0;
        tick();
        check("rr_quiet", 64'(busy_o), 0);

        // Snoop priority, starvation limit, simultaneous arrival.
        reset_dut();
        snoop_addr_i = 64'hC0FF_EE00;
        snoop_type_i = 4'h5;
        set_addr(2, 64'h2000);
        snoop_valid_i = 1'b1;
        cpu_req_i = 3'b100;
        repeat (4) push_snoop(64'hC0FF_EE00, 4'h5, 1'b0);
        push_cpu(2'd2, 1'b0, 64'h2000, 1'b1);
        push_snoop(64'hC0FF_EE00, 4'h5, 1'b1);
        repeat (6) begin
            wait_issue(n, e);
            finish_txn(e, 1, 1, 1'b0);
        end
        tick();
        check("snoop_quiet", 64'(busy_o), 0);

        // Controller gnt and done together, then the next request with a 1-cycle gap.
        set_addr(0, 64'h3000);
        set_addr(1, 64'h3040);
        cpu_we_i = 3'b010;
        cpu_req_i = 3'b011;
        push_cpu(2'd0, 1'b0, 64'h3000, 1'b1);
        push_cpu(2'd1, 1'b1, 64'h3040, 1'b1);
        wait_issue(n, e);
        finish_txn(e, 0, 0, 1'b1);
        wait_issue(n, e);
        check("t4_gap", 64'(n), 1);
        finish_txn(e, 0, 2, 1'b0);

        // Reset while waiting for done; stray done afterwards; pointer back at 0.
        set_addr(1, 64'h4000);
        cpu_req_i = 3'b010;
        push_cpu(2'd1, 1'b1, 64'h4000, 1'b1);
        wait_issue(n, e);
        ctrl_gnt_i = 1'b1;
        tick();
        ctrl_gnt_i = 1'b0;
        check("t5_wait_busy", 64'(busy_o), 1);
        reset_dut();
        check_zero("midreset");
        ctrl_done_i = 1'b1;
        tick();
        ctrl_done_i = 1'b0;
        check("stray_done_busy", 64'(busy_o), 0);
        check("stray_done_req", 64'(ctrl_req_o), 0);
        cpu_we_i = '0;
        set_addr(2, 64'h5000);
        cpu_req_i = 3'b110;
        push_cpu(2'd1, 1'b0, 64'h4000, 1'b1);
        push_cpu(2'd2, 1'b0, 64'h5000, 1'b1);
        repeat (2) begin
            wait_issue(n, e);
            finish_txn(e, 0, 1, 1'b0);
        end
        check("sb_drained", 64'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
